// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle for seg7_scan_mux: scan enable, BCD digits and dp requests in,
// active-low segment/anode drive and frame pulse out.
interface seg7_scan_mux_if;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;
  logic        frame_tick;

  modport master (
    output en, digits, dp_in,
    input  seg_out, dp_out, an_out, frame_tick
  );

  modport slave (
    input  en, digits, dp_in,
    output seg_out, dp_out, an_out, frame_tick
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 4-digit 7-segment driver with a per-frame digit snapshot.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_mux #(
  parameter int TERMINAL = 49999,
  parameter int PRE_W    = 16
) (
  input  logic            clock,
  input  logic            clear,
  seg7_scan_mux_if.slave  bus
);

  localparam logic [PRE_W-1:0] TERM_C = PRE_W'(TERMINAL);

  logic             r_active;
  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [15:0]      r_snap;
  logic [3:0]       r_dp_snap;
  logic             r_frame_tick;

  logic             w_tick;
  logic             w_last;
  logic             w_load;
  logic [PRE_W-1:0] w_pre_next;
  logic [1:0]       w_idx_next;
  logic [6:0]       w_seg_dig [4];
  logic [3:0]       w_blank;
  logic [6:0]       w_seg;
  logic             w_dp;
  logic [3:0]       w_an;

  function automatic logic [6:0] f_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

  // tick only counts once the scan has been running for a cycle, so the first
  // digit after an enable edge gets the same dwell as every other digit
  assign w_tick = bus.en & r_active & (r_pre == TERM_C);
  assign w_last = (r_idx == 2'd3);
  assign w_load = ~r_active | (w_tick & w_last);

  always_comb begin
    w_pre_next = r_pre;
    w_idx_next = r_idx;
    if (!bus.en) begin
      w_pre_next = '0;
      w_idx_next = 2'd0;
    end else if (!r_active) begin
      w_pre_next = '0;
    end else if (w_tick) begin
      w_pre_next = '0;
      w_idx_next = r_idx + 2'd1;
    end else begin
      w_pre_next = r_pre + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_active     <= 1'b0;
      r_pre        <= '0;
      r_idx        <= 2'd0;
      r_snap       <= 16'h0000;
      r_dp_snap    <= 4'h0;
      r_frame_tick <= 1'b0;
    end else begin
      r_active     <= bus.en;
      r_pre        <= w_pre_next;
      r_idx        <= w_idx_next;
      r_frame_tick <= w_tick & w_last;
      if (w_load) begin
        r_snap    <= bus.digits;
        r_dp_snap <= bus.dp_in;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign w_seg_dig[gi] = f_decode(r_snap[4*gi +: 4]);
`ifdef SEG7_LZB_EN
      // a digit is a leading zero when it and every digit above it are zero
      if (gi == 0) begin : g_keep
        assign w_blank[gi] = 1'b0;
      end else begin : g_lzb
        assign w_blank[gi] = (r_snap[15:4*gi] == '0);
      end
`else
      assign w_blank[gi] = 1'b0;
`endif
    end
  endgenerate

  always_comb begin
    w_seg = 7'h7F;
    w_dp  = 1'b1;
    w_an  = 4'hF;
    if (r_active && !w_blank[r_idx]) begin
      w_an  = ~(4'b0001 << r_idx);
      w_seg = w_seg_dig[r_idx];
      w_dp  = ~r_dp_snap[r_idx];
    end
  end

  assign bus.seg_out    = w_seg;
  assign bus.dp_out     = w_dp;
  assign bus.an_out     = w_an;
  assign bus.frame_tick = r_frame_tick;

endmodule
